dp_ram: RTL and testbench
=========================

DP_RAM -- requirements
Module: dp_ram

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Derived BE_W = DATA_W/8, byte-enable width; SHALL not be overridable.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 busy  out  1  high while post-reset clear runs; ports ignored.
REQ-007 cea / ceb  in  1  port A / B access enable.
REQ-008 wrea / wreb  in  1  port A / B write (1) or read (0); qualified by ce.
REQ-009 bea / beb  in  BE_W  port A / B byte enables for writes; bit i covers bits [8i+7:8i].
REQ-010 ada / adb  in  ADDR_W  port A / B word address.
REQ-011 dina / dinb  in  DATA_W  port A / B write data.
REQ-012 ocea / oceb  in  1  port A / B output-register enable; used only with DP_RAM_OUTREG_EN.
REQ-013 douta / doutb  out  DATA_W  port A / B read data.
REQ-014 coll  out  1  one-cycle pulse flagging a same-address write/write collision.

Function
REQ-015 FSM states: CLEAR, RUN; reset SHALL enter CLEAR with clear counter 0.
REQ-016 In CLEAR, one word per cycle SHALL be written to zero at the counter address, counter incrementing; busy=1.
REQ-017 CLEAR SHALL last exactly 2**ADDR_W cycles; after writing the last address, the FSM SHALL enter RUN and deassert busy on the next cycle.
REQ-018 While busy=1, all ce/wre inputs SHALL be ignored; douta/doutb SHALL hold zero.
REQ-019 Write: ce=1, wre=1 SHALL update only bytes with be=1 at the rising edge; be=0 SHALL be a no-op write.
REQ-020 Read: ce=1, wre=0 SHALL present mem[ad] on dout 1 cycle after the request (no output register).
REQ-021 With ce=0, dout SHALL hold its last value.
REQ-022 Write on a port SHALL leave that port's dout unchanged (no write-through).
REQ-023 Cross-port read of an address written the same cycle SHALL return the old data (read-first).
REQ-024 Both ports writing the same address the same cycle: port A bytes SHALL win where bea=1; port B SHALL supply bytes where bea=0 and beb=1; coll SHALL pulse high the next cycle.
REQ-025 coll SHALL assert only when both writes are active, addresses match and (bea & beb) != 0.
REQ-026 Addresses SHALL wrap naturally; no out-of-range condition exists.

Reset
REQ-027 reset asserted at any time, including mid-CLEAR or mid-access, SHALL restart CLEAR from address 0 on the next cycle.
REQ-028 Reset values: busy=1, douta=0, doutb=0, coll=0, output registers 0, clear counter 0.
REQ-029 Memory contents are not reset directly; they SHALL be zero only after CLEAR completes.

Configuration
REQ-030 Macro DP_RAM_OUTREG_EN defined: each port SHALL add an output register loaded when oce=1; read latency 2 cycles; oce=0 holds dout.
REQ-031 Macro undefined: read latency 1 cycle; ocea/oceb SHALL be ignored.

Verification
REQ-032 Reset 1 cycle, release -> busy high exactly 32 cycles (defaults), then 0; read of every address returns 0x00000000.
REQ-033 Port A writes 0xDEADBEEF to address 3, bea=4'b1111; port B reads address 3 next cycle -> doutb=0xDEADBEEF one cycle later (two with OUTREG, oceb=1).
REQ-034 Address 7 holds 0x11223344; port A writes 0xAABBCCDD with bea=4'b0101 -> read returns 0x11BB33DD.
REQ-035 Same cycle: A writes 0xAAAAAAAA bea=4'b0011, B writes 0xBBBBBBBB beb=4'b1111, both address 9 -> mem[9]=0xBBBBAAAA, coll=1 for exactly one cycle.
REQ-036 Address 2 holds 0x5; A writes 0x6 to 2 while B reads 2 the same cycle -> doutb=0x5; subsequent B read -> 0x6.
REQ-037 reset pulsed at clear counter 10 -> busy stays high for a further full 32 cycles; all reads return 0.

Source files
------------

// File: rtl/dp_ram.sv
// -----------------------------------------------------------------------------
// dp_ram : true dual-port RAM with byte enables and a self-clearing start-up.
//
// After reset the RAM walks every address writing zero (busy=1). Port
// accesses are ignored during that walk. Afterwards both ports read and write
// independently. Reads are read-first: a read returns the contents from before
// any write in the same cycle. On a same-address write/write, port A wins on
// its enabled bytes and port B fills the remaining enabled bytes. coll pulses
// for one cycle when those enabled bytes overlap.
//
// Optional build macro: DP_RAM_OUTREG_EN
//   defined   : adds a per-port output register loaded when oce=1 (latency 2)
//   undefined : latency 1, ocea/oceb are ignored
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous active-high reset
//   busy            high while the post-reset clear runs
//   cea/ceb         port access enable
//   wrea/wreb       1 = write, 0 = read (qualified by ce)
//   bea/beb         byte enables for writes
//   ada/adb         word address
//   dina/dinb       write data
//   ocea/oceb       output register enable (DP_RAM_OUTREG_EN only)
//   douta/doutb     read data
//   coll            one-cycle pulse on an overlapping same-address write pair
// -----------------------------------------------------------------------------
module dp_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  busy,
   input  logic                  cea,
   input  logic                  ceb,
   input  logic                  wrea,
   input  logic                  wreb,
   input  logic [DATA_W/8-1:0]   bea,
   input  logic [DATA_W/8-1:0]   beb,
   input  logic [ADDR_W-1:0]     ada,
   input  logic [ADDR_W-1:0]     adb,
   input  logic [DATA_W-1:0]     dina,
   input  logic [DATA_W-1:0]     dinb,
   input  logic                  ocea,
   input  logic                  oceb,
   output logic [DATA_W-1:0]     douta,
   output logic [DATA_W-1:0]     doutb,
   output logic                  coll
);

   // state   | meaning
   // S_CLEAR | zeroing memory, one word per cycle at clr_cnt_q; busy=1
   // S_RUN   | normal dual-port operation

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]   douta_q, douta_d;
   logic [DATA_W-1:0]   doutb_q, doutb_d;
   logic                coll_q, coll_d;
   logic                clr_we;
   logic                run;
   logic                wr_a, wr_b, rd_a, rd_b;

   logic [DATA_W-1:0]   mem [DEPTH];

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      clr_we    = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            state_d = S_RUN;
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   assign run  = (state_q == S_RUN);
   assign wr_a = run & cea &  wrea;
   assign wr_b = run & ceb &  wreb;
   assign rd_a = run & cea & ~wrea;
   assign rd_b = run & ceb & ~wreb;

   assign coll_d = wr_a & wr_b & (ada == adb) & (|(bea & beb));

   // Memory is deliberately not reset; the CLEAR walk zeroes it.
   // Port B bytes are assigned before port A so A wins on shared bytes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (clr_we) begin
            mem[clr_cnt_q] <= '0;
         end
         for (int i = 0; i < BE_W; i++) begin
            if (wr_b && beb[i]) begin
               mem[adb][8*i +: 8] <= dinb[8*i +: 8];
            end
            if (wr_a && bea[i]) begin
               mem[ada][8*i +: 8] <= dina[8*i +: 8];
            end
         end
      end
   end

`ifdef DP_RAM_OUTREG_EN
   logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;

   always_comb begin
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      douta_d   = douta_q;
      doutb_d   = doutb_q;
      if (rd_a) begin
         rdata_a_d = mem[ada];
      end
      if (rd_b) begin
         rdata_b_d = mem[adb];
      end
      if (run && ocea) begin
         douta_d = rdata_a_q;
      end
      if (run && oceb) begin
         doutb_d = rdata_b_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end
`else
   logic unused_oce;
   assign unused_oce = ocea ^ oceb;

   always_comb begin
      douta_d = douta_q;
      doutb_d = doutb_q;
      if (rd_a) begin
         douta_d = mem[ada];
      end
      if (rd_b) begin
         doutb_d = mem[adb];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_CLEAR;
         clr_cnt_q <= '0;
         douta_q   <= '0;
         doutb_q   <= '0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         douta_q   <= douta_d;
         doutb_q   <= doutb_d;
         coll_q    <= coll_d;
      end
   end

   assign busy  = (state_q == S_CLEAR);
   assign douta = douta_q;
   assign doutb = doutb_q;
   assign coll  = coll_q;

endmodule

// File: tb/tb_dp_ram.sv
module tb_dp_ram;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int BE_W   = DATA_W / 8;
   localparam int DEPTH  = 2 ** ADDR_W;

   logic                clk = 1'b0;
   logic                reset;
   logic                busy;
   logic                cea, ceb, wrea, wreb;
   logic [BE_W-1:0]     bea, beb;
   logic [ADDR_W-1:0]   ada, adb;
   logic [DATA_W-1:0]   dina, dinb;
   logic                ocea, oceb;
   logic [DATA_W-1:0]   douta, doutb;
   logic                coll;

   int checks = 0;
   int errors = 0;

   // reference model: word array plus expected registered outputs
   logic [DATA_W-1:0]   model_mem [DEPTH];
   logic [DATA_W-1:0]   exp_a, exp_b;
   logic                exp_coll;
   int                  busy_left;

   dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .busy  (busy),
      .cea   (cea),
      .ceb   (ceb),
      .wrea  (wrea),
      .wreb  (wreb),
      .bea   (bea),
      .beb   (beb),
      .ada   (ada),
      .adb   (adb),
      .dina  (dina),
      .dinb  (dinb),
      .ocea  (ocea),
      .oceb  (oceb),
      .douta (douta),
      .doutb (doutb),
      .coll  (coll)
   );

   always #5 clk = ~clk;

   task automatic set_idle();
      cea = 0; ceb = 0; wrea = 0; wreb = 0;
      bea = '0; beb = '0; ada = '0; adb = '0;
      dina = '0; dinb = '0; ocea = 1; oceb = 1;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      logic [DATA_W-1:0] ra, rb;
      if (reset) begin
         busy_left = DEPTH;
         exp_a = '0; exp_b = '0; exp_coll = 1'b0;
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end else if (busy_left > 0) begin
         busy_left = busy_left - 1;
         exp_coll = 1'b0;
      end else begin
         ra = model_mem[ada];
         rb = model_mem[adb];
         if (cea && !wrea) exp_a = ra;
         if (ceb && !wreb) exp_b = rb;
         exp_coll = cea && wrea && ceb && wreb && (ada == adb) && ((bea & beb) != 0);
         if (ceb && wreb)
            for (int i = 0; i < BE_W; i++)
               if (beb[i]) model_mem[adb][8*i +: 8] = dinb[8*i +: 8];
         if (cea && wrea)
            for (int i = 0; i < BE_W; i++)
               if (bea[i]) model_mem[ada][8*i +: 8] = dina[8*i +: 8];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int n;
      set_idle();
      reset = 1;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
      checks++; if (douta !== '0) begin errors++; $display("FAIL reset_douta got %h want 0", douta); end
      checks++; if (doutb !== '0) begin errors++; $display("FAIL reset_doutb got %h want 0", doutb); end
      checks++; if (coll !== 1'b0) begin errors++; $display("FAIL reset_coll got %b want 0", coll); end
      reset = 0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin tick(); n++; end
      checks++; if (n != DEPTH) begin errors++; $display("FAIL clear_length got %0d want %0d", n, DEPTH); end
   endtask

   task automatic test_clear_contents();
      for (int i = 0; i < DEPTH; i++) begin
         set_idle();
         cea = 1; ada = ADDR_W'(i);
         ceb = 1; adb = ADDR_W'(DEPTH - 1 - i);
         tick();
         checks++; if (douta !== '0) begin errors++; $display("FAIL clear_read_a addr %0d got %h want 0", i, douta); end
         checks++; if (doutb !== '0) begin errors++; $display("FAIL clear_read_b addr %0d got %h want 0", DEPTH-1-i, doutb); end
      end
   endtask

   task automatic test_write_read();
      set_idle();
      cea = 1; wrea = 1; ada = 3; bea = 4'hF; dina = 32'hDEADBEEF;
      tick();
      set_idle();
      ceb = 1; adb = 3;
      tick();
      set_idle();
      checks++; if (doutb !== 32'hDEADBEEF) begin errors++; $display("FAIL cross_read got %h want deadbeef", doutb); end
   endtask

   task automatic test_byte_enable();
      logic [DATA_W-1:0] held;
      set_idle();
      cea = 1; wrea = 1; ada = 7; bea = 4'hF; dina = 32'h11223344;
      tick();
      set_idle();
      cea = 1; ada = 3;
      tick();
      held = douta;
      set_idle();
      cea = 1; wrea = 1; ada = 7; bea = 4'b0101; dina = 32'hAABBCCDD;
      tick();
      checks++; if (douta !== 32'hDEADBEEF) begin errors++; $display("FAIL no_write_through got %h want deadbeef", douta); end
      set_idle();
      cea = 1; wrea = 1; ada = 7; bea = 4'b0000; dina = 32'hFFFFFFFF;
      tick();
      set_idle();
      cea = 1; ada = 7;
      tick();
      set_idle();
      checks++; if (douta !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enable got %h want 11bb33dd", douta); end
      checks++; if (held !== 32'hDEADBEEF) begin errors++; $display("FAIL read_a_addr3 got %h want deadbeef", held); end
      // ce low holds the last read value
      repeat (3) tick();
      checks++; if (douta !== 32'h11BB33DD) begin errors++; $display("FAIL ce_hold got %h want 11bb33dd", douta); end
   endtask

   task automatic test_collision();
      set_idle();
      cea = 1; wrea = 1; ada = 9; bea = 4'b0011; dina = 32'hAAAAAAAA;
      ceb = 1; wreb = 1; adb = 9; beb = 4'b1111; dinb = 32'hBBBBBBBB;
      tick();
      set_idle();
      checks++; if (coll !== 1'b1) begin errors++; $display("FAIL coll_pulse got %b want 1", coll); end
      cea = 1; ada = 9;
      tick();
      set_idle();
      checks++; if (coll !== 1'b0) begin errors++; $display("FAIL coll_width got %b want 0", coll); end
      checks++; if (douta !== 32'hBBBBAAAA) begin errors++; $display("FAIL coll_merge got %h want bbbbaaaa", douta); end
      cea = 1; wrea = 1; ada = 10; bea = 4'b0011; dina = 32'h12345678;
      ceb = 1; wreb = 1; adb = 10; beb = 4'b1100; dinb = 32'h9ABCDEF0;
      tick();
      set_idle();
      checks++; if (coll !== 1'b0) begin errors++; $display("FAIL coll_disjoint got %b want 0", coll); end
      cea = 1; ada = 10;
      tick();
      set_idle();
      checks++; if (douta !== 32'h9ABC5678) begin errors++; $display("FAIL disjoint_merge got %h want 9abc5678", douta); end
   endtask

   task automatic test_read_first();
      set_idle();
      cea = 1; wrea = 1; ada = 2; bea = 4'hF; dina = 32'h5;
      tick();
      set_idle();
      cea = 1; wrea = 1; ada = 2; bea = 4'hF; dina = 32'h6;
      ceb = 1; adb = 2;
      tick();
      set_idle();
      checks++; if (doutb !== 32'h5) begin errors++; $display("FAIL read_first_old got %h want 5", doutb); end
      ceb = 1; adb = 2;
      tick();
      set_idle();
      checks++; if (doutb !== 32'h6) begin errors++; $display("FAIL read_first_new got %h want 6", doutb); end
   endtask

   task automatic test_reset_mid_clear();
      int n;
      int bad;
      set_idle();
      reset = 1;
      tick();
      checks++; if (douta !== '0 || doutb !== '0) begin errors++; $display("FAIL reset_mid_access got %h/%h want 0/0", douta, doutb); end
      reset = 0;
      repeat (10) tick();
      reset = 1;
      tick();
      reset = 0;
      // drive a colliding write pair and reads while busy: must be ignored
      cea = 1; wrea = 1; ada = 31; bea = 4'hF; dina = 32'hCAFEF00D;
      ceb = 1; wreb = 1; adb = 31; beb = 4'hF; dinb = 32'h0BADF00D;
      n = 0; bad = 0;
      while (busy === 1'b1 && n < 100) begin
         tick();
         n++;
         if (busy === 1'b1 && (douta !== '0 || doutb !== '0 || coll !== 1'b0)) bad++;
         wrea = n[0]; wreb = n[0];
      end
      set_idle();
      checks++; if (n != DEPTH) begin errors++; $display("FAIL reclear_length got %0d want %0d", n, DEPTH); end
      checks++; if (bad != 0) begin errors++; $display("FAIL busy_outputs got %0d bad cycles want 0", bad); end
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         cea = 1; ada = ADDR_W'(i);
         ceb = 1; adb = ADDR_W'(i);
         tick();
         if (douta !== '0 || doutb !== '0) bad++;
      end
      set_idle();
      checks++; if (bad != 0) begin errors++; $display("FAIL reclear_contents got %0d nonzero want 0", bad); end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int n = 0; n < 400; n++) begin
         cea  = ($urandom_range(0, 3) != 0);
         ceb  = ($urandom_range(0, 3) != 0);
         wrea = $urandom_range(0, 1);
         wreb = $urandom_range(0, 1);
         bea  = BE_W'($urandom);
         beb  = BE_W'($urandom);
         ada  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 3));
         adb  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 3));
         dina = $urandom;
         dinb = $urandom;
         tick();
         checks++; if (douta !== exp_a) begin errors++; $display("FAIL rand_douta cycle %0d got %h want %h", n, douta, exp_a); end
         checks++; if (doutb !== exp_b) begin errors++; $display("FAIL rand_doutb cycle %0d got %h want %h", n, doutb, exp_b); end
         checks++; if (coll !== exp_coll) begin errors++; $display("FAIL rand_coll cycle %0d got %b want %b", n, coll, exp_coll); end
         if (busy !== 1'b0) bad++;
      end
      set_idle();
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_busy got %0d busy cycles want 0", bad); end
      // sweep every word through both ports against the model
      bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         cea = 1; ada = ADDR_W'(i);
         ceb = 1; adb = ADDR_W'(DEPTH - 1 - i);
         tick();
         if (douta !== model_mem[i] || doutb !== model_mem[DEPTH - 1 - i]) bad++;
      end
      set_idle();
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_sweep got %0d wrong words want 0", bad); end
   endtask

   initial begin
      reset = 1;
      busy_left = DEPTH;
      exp_a = '0; exp_b = '0; exp_coll = 1'b0;
      set_idle();
      test_reset();
      test_clear_contents();
      test_write_read();
      test_byte_enable();
      test_collision();
      test_read_first();
      test_reset_mid_clear();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
